// File: rtl/exu_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : exu_pc_seq
//  Purpose  : Sequential PC unit. Owns the architectural PC, issues fetch
//             requests to the IFU, waits for the EXU to resolve the fetched
//             instruction, then computes the next PC (seq / jal / jalr /
//             branch). An ebreak parks the unit in HALT until reset.
//  Optional : PC_MISALIGN_TRAP_EN - when defined, a next-PC target whose low
//             two bits are non-zero is replaced by TRAP_VEC and the misalign
//             pulse fires. When undefined the target is loaded as-is and
//             misalign is constant 0.
//  Ports    : clk, rst         - clock (rising edge), async active-high reset
//             pc, pc_valid     - fetch request towards the IFU
//             pc_ready         - IFU accepts the fetch request
//             ex_ready         - unit is waiting for the EXU resolution
//             ex_valid         - EXU result valid
//             ex_kind          - 0=seq 1=jal 2=jalr 3=branch
//             ex_taken         - branch condition (used when ex_kind=3)
//             ex_imm, ex_src1  - sign-extended immediate, rs1 (jalr base)
//             ex_halt          - resolved instruction is ebreak
//             retire           - one-cycle pulse, instruction retired
//             halted           - unit is in HALT
//             misalign         - one-cycle pulse, misaligned target trapped
//  Revision : 1.0 - initial release
// ============================================================================
module exu_pc_seq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h8000_0100
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic            ex_ready,
    input  logic            ex_valid,
    input  logic [1:0]      ex_kind,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_src1,
    input  logic            ex_halt,
    output logic            retire,
    output logic            halted,
    output logic            misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] KIND_SEQ    = 2'd0;
    localparam logic [1:0] KIND_JAL    = 2'd1;
    localparam logic [1:0] KIND_JALR   = 2'd2;
    localparam logic [1:0] KIND_BRANCH = 2'd3;

    state_t          state;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            trap_hit;

    // All adders are XLEN wide; the carry out is simply dropped so every
    // target wraps modulo 2^XLEN.
    assign pc_plus4    = pc + XLEN'(4);
    assign pc_plus_imm = pc + ex_imm;
    assign jalr_sum    = ex_src1 + ex_imm;

    always_comb begin
        target = pc_plus4;
        case (ex_kind)
            KIND_SEQ:    target = pc_plus4;
            KIND_JAL:    target = pc_plus_imm;
            KIND_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
            KIND_BRANCH: target = ex_taken ? pc_plus_imm : pc_plus4;
            default:     target = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Checked after the jalr bit-0 clear, so only bit 1 can trip it for jalr.
    assign trap_hit = (target[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    assign next_pc = trap_hit ? TRAP_VEC : target;

    // Single state machine; every output is a flop updated alongside the
    // state so nothing combinational reaches the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_VEC;
            pc_valid <= 1'b0;
            ex_ready <= 1'b0;
            retire   <= 1'b0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised only for one cycle.
            retire   <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    pc_valid <= 1'b1;
                end
                FETCH: begin
                    if (pc_ready) begin
                        state    <= EXEC;
                        pc_valid <= 1'b0;
                        ex_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    if (ex_valid) begin
                        ex_ready <= 1'b0;
                        retire   <= 1'b1;
                        if (ex_halt) begin
                            // ebreak retires but leaves the PC where it is.
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            pc       <= next_pc;
                            pc_valid <= 1'b1;
                            misalign <= trap_hit;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exu_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exu_pc_seq
//  Purpose  : Self-checking bench for exu_pc_seq. A behavioural model of the
//             fetch/execute protocol predicts every output each cycle; a few
//             directed scenarios pin the model with literal expectations, then
//             randomized traffic (with random resets) exercises the rest.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exu_pc_seq;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h8000_0000;
    localparam logic [31:0] TV   = 32'h8000_0100;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready = 1'b0;
    logic        ex_ready;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_kind  = 2'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_imm   = 32'd0;
    logic [31:0] ex_src1  = 32'd0;
    logic        ex_halt  = 1'b0;
    logic        retire;
    logic        halted;
    logic        misalign;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exu_pc_seq #(
        .XLEN      (XLEN),
        .RESET_VEC (RV),
        .TRAP_VEC  (TV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .pc_valid (pc_valid),
        .pc_ready (pc_ready),
        .ex_ready (ex_ready),
        .ex_valid (ex_valid),
        .ex_kind  (ex_kind),
        .ex_taken (ex_taken),
        .ex_imm   (ex_imm),
        .ex_src1  (ex_src1),
        .ex_halt  (ex_halt),
        .retire   (retire),
        .halted   (halted),
        .misalign (misalign)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Architectural next-PC rule, straight arithmetic.
    function automatic logic [31:0] ref_target(input logic [1:0] k, input logic t,
                                               input logic [31:0] imm, input logic [31:0] s1,
                                               input logic [31:0] cur);
        case (k)
            2'd0:    return cur + 32'd4;
            2'd1:    return cur + imm;
            2'd2:    return (s1 + imm) & 32'hFFFF_FFFE;
            default: return t ? cur + imm : cur + 32'd4;
        endcase
    endfunction

    // ---------------- model + per-cycle compare ----------------
    int          m_phase  = P_IDLE;
    logic [31:0] m_pc     = RV;
    logic        m_retire = 1'b0;
    logic        m_mis    = 1'b0;

    always @(negedge clk) begin : cmp
        logic [31:0] t;
        if (rst) begin
            m_phase  = P_IDLE;
            m_pc     = RV;
            m_retire = 1'b0;
            m_mis    = 1'b0;
        end
        chk("pc",       pc,       m_pc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_phase == P_FETCH});
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, m_phase == P_EXEC});
        chk("halted",   {31'd0, halted},   {31'd0, m_phase == P_HALT});
        chk("retire",   {31'd0, retire},   {31'd0, m_retire});
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
        if (!rst) begin
            // Predict the state after the coming rising edge.
            m_retire = 1'b0;
            m_mis    = 1'b0;
            case (m_phase)
                P_IDLE:  m_phase = P_FETCH;
                P_FETCH: if (pc_ready) m_phase = P_EXEC;
                P_EXEC: begin
                    if (ex_valid) begin
                        m_retire = 1'b1;
                        if (ex_halt) begin
                            m_phase = P_HALT;
                        end else begin
                            t = ref_target(ex_kind, ex_taken, ex_imm, ex_src1, m_pc);
`ifdef PC_MISALIGN_TRAP_EN
                            if (t[1:0] != 2'b00) begin
                                t     = TV;
                                m_mis = 1'b1;
                            end
`endif
                            m_pc    = t;
                            m_phase = P_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec();
        int n = 0;
        while (!ex_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("exec_timeout", 32'd1, 32'd0);
    endtask

    // Present one EXU result once the unit asks for it; returns #1 after the
    // edge that consumed it.
    task automatic exec_instr(input logic [1:0] k, input logic t, input logic [31:0] imm,
                              input logic [31:0] s1, input logic h);
        pc_ready = 1'b1;
        ex_valid = 1'b0;
        wait_exec();
        ex_valid = 1'b1;
        ex_kind  = k;
        ex_taken = t;
        ex_imm   = imm;
        ex_src1  = s1;
        ex_halt  = h;
        tick();
        ex_valid = 1'b0;
        ex_halt  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;

        // 1: reset and first fetch
        pc_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
        tick();
        chk("first_fetch", {31'd0, pc_valid}, 32'd1);

        // 2: sequential
        exec_instr(2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("seq_pc", pc, 32'h8000_0004);
        chk("seq_retire", {31'd0, retire}, 32'd1);
        chk("seq_next_fetch", {31'd0, pc_valid}, 32'd1);
        tick();
        chk("seq_retire_pulse", {31'd0, retire}, 32'd0);

        // 3: branches around 0x80000010
        exec_instr(2'd1, 1'b0, 32'h0000_000C, 32'd0, 1'b0);
        chk("jal_pc", pc, 32'h8000_0010);
        exec_instr(2'd3, 1'b1, 32'hFFFF_FFF8, 32'd0, 1'b0);
        chk("br_taken", pc, 32'h8000_0008);
        exec_instr(2'd1, 1'b0, 32'h0000_0008, 32'd0, 1'b0);
        exec_instr(2'd3, 1'b0, 32'hFFFF_FFF8, 32'd0, 1'b0);
        chk("br_not_taken", pc, 32'h8000_0014);

        // 4: jalr bit-0 clear and wrap-around
        exec_instr(2'd2, 1'b0, 32'h0000_0001, 32'h8000_0103, 1'b0);
        chk("jalr_pc", pc, 32'h8000_0104);
        exec_instr(2'd2, 1'b0, 32'h0000_000C, 32'hFFFF_FFF0, 1'b0);
        chk("jalr_top", pc, 32'hFFFF_FFFC);
        exec_instr(2'd1, 1'b0, 32'h0000_0008, 32'd0, 1'b0);
        chk("jal_wrap", pc, 32'h0000_0004);

        // 5: misaligned jal target
        exec_instr(2'd2, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        exec_instr(2'd1, 1'b0, 32'h0000_0006, 32'd0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign_pc", pc, 32'h8000_0100);
        chk("misalign_pulse", {31'd0, misalign}, 32'd1);
`else
        chk("misalign_pc", pc, 32'h8000_0006);
        chk("misalign_pulse", {31'd0, misalign}, 32'd0);
`endif

        // 6: ebreak halts; inputs are ignored afterwards
        held = pc;
        exec_instr(2'd1, 1'b0, 32'h0000_0040, 32'd0, 1'b1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_retire", {31'd0, retire}, 32'd1);
        chk("halt_pc", pc, held);
        ex_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold_pc", pc, held);
            chk("halt_no_fetch", {31'd0, pc_valid | ex_ready | retire}, 32'd0);
        end
        ex_valid = 1'b0;

        // reset in the middle of EXEC
        do_reset();
        exec_instr(2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_exec();
        rst = 1'b1;
        #1;
        chk("rst_exec_pc", pc, 32'h8000_0000);
        chk("rst_exec_ready", {31'd0, ex_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_exec_refetch", {31'd0, pc_valid}, 32'd1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 59) == 0) rst = 1'b1;
            pc_ready = ($urandom_range(0, 2) != 0);
            ex_valid = ($urandom_range(0, 2) != 0);
            ex_kind  = 2'($urandom_range(0, 3));
            ex_taken = 1'($urandom_range(0, 1));
            ex_halt  = ($urandom_range(0, 24) == 0);
            r        = $urandom;
            ex_imm   = {{24{r[7]}}, r[7:0]};
            if ($urandom_range(0, 3) != 0) ex_imm[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) ex_imm = $urandom;
            ex_src1  = $urandom;
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
